// File: rtl/shift_transmitter.sv
// TDO serializer: captures a word on load, shifts N bits out on falling TCK edges, flags done.
// Optional odd-parity tail bit enabled by defining SHIFT_TRANSMITTER_PARITY_EN.
module shift_transmitter #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          LSB_FIRST = 1'b0,
   parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk_tck,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic [CNT_W-1:0] len,
   output logic             out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
`ifdef SHIFT_TRANSMITTER_PARITY_EN
      PARITY = 2'd2,
`endif
      DONE   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             out_nxt, busy_nxt, done_nxt;
   logic [CNT_W-1:0] n_eff, shamt;
   logic [WIDTH-1:0] aligned;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
   logic             acc, acc_nxt;
`endif

   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] x);
      return LSB_FIRST ? (x >> 1) : (x << 1);
   endfunction

   function automatic logic head(input logic [WIDTH-1:0] x);
      return LSB_FIRST ? x[0] : x[WIDTH-1];
   endfunction

   // MSB order left-aligns the selected bits so the head is always the top bit.
   always_comb begin
      n_eff   = ((len == '0) || (len > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : len;
      shamt   = CNT_W'(WIDTH) - n_eff;
      aligned = LSB_FIRST ? in : (in << shamt);
   end

   always_ff @(negedge clk_tck) begin
      if (reset) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         out   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
         acc   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         cnt   <= cnt_nxt;
         out   <= out_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
         acc   <= acc_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      out_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
      acc_nxt   = acc;
`endif
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  sr_nxt    = shift1(aligned);
                  cnt_nxt   = n_eff - CNT_W'(1);
                  out_nxt   = head(aligned);
                  busy_nxt  = 1'b1;
                  state_nxt = SHIFT;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
                  acc_nxt   = head(aligned);
`endif
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  out_nxt  = head(sr);
                  sr_nxt   = shift1(sr);
                  cnt_nxt  = cnt - CNT_W'(1);
                  busy_nxt = 1'b1;
`ifdef SHIFT_TRANSMITTER_PARITY_EN
                  acc_nxt  = acc ^ head(sr);
`endif
               end else begin
`ifdef SHIFT_TRANSMITTER_PARITY_EN
                  state_nxt = PARITY;
                  out_nxt   = ~acc;
                  busy_nxt  = 1'b1;
`else
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
`endif
               end
            end
`ifdef SHIFT_TRANSMITTER_PARITY_EN
            PARITY: begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end
`endif
            DONE: begin
               done_nxt = 1'b1;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_transmitter.sv
// Bench for shift_transmitter: MSB-first and LSB-first instances share stimulus; a per-edge
// scoreboard of expected out/busy/done is filled as stimulus is driven and drained after each edge.
module tb_shift_transmitter;

   logic        clk_tck = 1'b0;
   logic        reset, enable, load;
   logic [31:0] in;
   logic [5:0]  len;
   logic        out_m, busy_m, done_m;
   logic        out_l, busy_l, done_l;

   typedef struct packed {
      logic o;
      logic b;
      logic d;
   } exp_t;

   exp_t q_m[$];
   exp_t q_l[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk_tck = ~clk_tck;

   shift_transmitter #(.WIDTH(32), .LSB_FIRST(1'b0)) u_msb (
      .clk_tck(clk_tck), .reset(reset), .enable(enable), .load(load),
      .in(in), .len(len), .out(out_m), .busy(busy_m), .done(done_m)
   );

   shift_transmitter #(.WIDTH(32), .LSB_FIRST(1'b1)) u_lsb (
      .clk_tck(clk_tck), .reset(reset), .enable(enable), .load(load),
      .in(in), .len(len), .out(out_l), .busy(busy_l), .done(done_l)
   );

   function automatic logic pick(input logic [31:0] w, input int n, input int k, input bit lsb);
      return lsb ? w[k] : w[n-1-k];
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_both(input logic om, input logic ol, input logic b, input logic d);
      exp_t e;
      e.o = om; e.b = b; e.d = d;
      q_m.push_back(e);
      e.o = ol;
      q_l.push_back(e);
   endtask

   task automatic tick(input string tag);
      exp_t e;
      @(negedge clk_tck);
      #1;
      if (q_m.size() == 0 || q_l.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      end else begin
         e = q_m.pop_front();
         chk($sformatf("%s msb.out", tag),  out_m,  e.o);
         chk($sformatf("%s msb.busy", tag), busy_m, e.b);
         chk($sformatf("%s msb.done", tag), done_m, e.d);
         e = q_l.pop_front();
         chk($sformatf("%s lsb.out", tag),  out_l,  e.o);
         chk($sformatf("%s lsb.busy", tag), busy_l, e.b);
         chk($sformatf("%s lsb.done", tag), done_l, e.d);
      end
   endtask

   // stop_kind: 0 none, 1 drop enable at bit stop_at, 2 reset (with load high) at bit stop_at
   task automatic xfer(input string tag, input logic [31:0] w, input logic [5:0] lreq,
                       input int stop_at, input int stop_kind, input bit mutate);
      int   n;
      logic x;
      n = (lreq == 6'd0 || lreq > 6'd32) ? 32 : int'(lreq);
      enable = 1'b1; load = 1'b1; in = w; len = lreq;
      x = pick(w, n, 0, 1'b0);
      push_both(pick(w, n, 0, 1'b0), pick(w, n, 0, 1'b1), 1'b1, 1'b0);
      tick(tag);
      load = mutate;
      if (mutate) begin
         in  = 32'h0;
         len = 6'd1;
      end
      for (int k = 1; k < n; k++) begin
         if (k == stop_at) begin
            if (stop_kind == 1) enable = 1'b0;
            else begin
               reset = 1'b1;
               load  = 1'b1;
            end
            push_both(1'b0, 1'b0, 1'b0, 1'b0);
            tick(tag);
            if (stop_kind == 2) begin
               push_both(1'b0, 1'b0, 1'b0, 1'b0);
               tick(tag);
               reset = 1'b0;
               load  = 1'b0;
               push_both(1'b0, 1'b0, 1'b0, 1'b0);
               tick(tag);
            end
            enable = 1'b0;
            load   = 1'b0;
            push_both(1'b0, 1'b0, 1'b0, 1'b0);
            tick(tag);
            return;
         end
         x ^= pick(w, n, k, 1'b0);
         push_both(pick(w, n, k, 1'b0), pick(w, n, k, 1'b1), 1'b1, 1'b0);
         tick(tag);
      end
`ifdef SHIFT_TRANSMITTER_PARITY_EN
      push_both(~x, ~x, 1'b1, 1'b0);
      tick($sformatf("%s parity", tag));
`endif
      push_both(1'b0, 1'b0, 1'b0, 1'b1);
      tick($sformatf("%s done", tag));
      push_both(1'b0, 1'b0, 1'b0, 1'b1);
      tick($sformatf("%s done_hold", tag));
      enable = 1'b0;
      load   = 1'b0;
      push_both(1'b0, 1'b0, 1'b0, 1'b0);
      tick($sformatf("%s idle", tag));
   endtask

   initial begin
      logic [31:0] rw;
      logic [5:0]  rl;
      reset = 1'b1; enable = 1'b0; load = 1'b0; in = 32'h0; len = 6'd0;
      push_both(1'b0, 1'b0, 1'b0, 1'b0);
      tick("reset");
      enable = 1'b1; load = 1'b1; in = 32'hFFFF_FFFF;
      push_both(1'b0, 1'b0, 1'b0, 1'b0);
      tick("reset_over_load");
      reset = 1'b0; load = 1'b0; enable = 1'b0;
      push_both(1'b0, 1'b0, 1'b0, 1'b0);
      tick("idle");

      xfer("full",        32'hDEAD_BEEF, 6'd0,  -1, 0, 1'b0);
      xfer("short4",      32'h0000_000A, 6'd4,  -1, 0, 1'b0);
      xfer("isolate",     32'hDEAD_BEEF, 6'd0,  -1, 0, 1'b1);
      xfer("abort",       32'hDEAD_BEEF, 6'd0,   5, 1, 1'b0);
      xfer("after_abort", 32'h0000_0001, 6'd0,  -1, 0, 1'b0);
      xfer("reset_mid",   32'h1234_5678, 6'd0,   3, 2, 1'b0);
      xfer("len1",        32'h0000_0001, 6'd1,  -1, 0, 1'b0);
      xfer("len_over",    32'hCAFE_F00D, 6'd40, -1, 0, 1'b0);
      xfer("par07",       32'h0000_0007, 6'd8,  -1, 0, 1'b0);
      xfer("par03",       32'h0000_0003, 6'd8,  -1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         rw = $urandom;
         rl = 6'($urandom_range(1, 32));
         xfer($sformatf("rand%0d", i), rw, rl, -1, 0, 1'b0);
      end

      if (q_m.size() != 0 || q_l.size() != 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL sb_leftover observed=%0d expected=0", q_m.size() + q_l.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
